// File: rtl/voodoo_sha_core.sv
// voodoo_sha_core: iterative SHA-256 compression engine, UNROLL rounds per clock,
// message schedule expanded on the fly, optional midstate feed-forward.
module voodoo_sha_core #(
    parameter int UNROLL      = 1,
    parameter int FEEDFORWARD = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] midstate,
    input  logic [511:0] block,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
              UNROLL == 16 || UNROLL == 32 || UNROLL == 64)) begin : g_bad_unroll
            $error("voodoo_sha_core: UNROLL must be one of 1, 2, 4, 8, 16, 32, 64");
        end
    endgenerate

    localparam logic [6:0] last_cnt = 7'(64 - UNROLL);

    localparam logic [31:0] k_rom [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // state    | meaning
    // st_idle  | waiting for a job, in_ready high
    // st_round | UNROLL compression rounds per clock
    // st_final | feed-forward and digest register load
    // st_done  | digest presented, waiting for out_ready
    typedef enum logic [1:0] {st_idle, st_round, st_final, st_done} state_t;

    state_t      state, state_nxt;
    logic        load, step, capture;

    logic [31:0] wk  [8];
    logic [31:0] ms  [8];
    logic [31:0] win [16];
    logic [6:0]  cnt;

    logic [31:0] ext  [16+UNROLL];
    logic [31:0] rs   [UNROLL+1][8];
    logic [31:0] nwin [16];
    logic [255:0] fin;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        case (state)
            st_idle: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = st_round;
                end
            end
            st_round: begin
                step = 1'b1;
                if (abort) begin
                    state_nxt = st_idle;
                end else if (cnt == last_cnt) begin
                    state_nxt = st_final;
                end
            end
            st_final: begin
                if (abort) begin
                    state_nxt = st_idle;
                end else begin
                    capture   = 1'b1;
                    state_nxt = st_done;
                end
            end
            st_done: begin
                if (abort || out_ready) begin
                    state_nxt = st_idle;
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    assign in_ready  = (state == st_idle);
    assign busy      = (state != st_idle);
    assign out_valid = (state == st_done);

    // ext[0..15] is the live window; ext[16..] are the words produced this clock
    always_comb begin
        logic [31:0] t1, t2;
        t1 = '0;
        t2 = '0;
        for (int j = 0; j < 16; j++) begin
            ext[j] = win[j];
        end
        for (int j = 16; j < 16 + UNROLL; j++) begin
            ext[j] = ext[j-16] + ssig0(ext[j-15]) + ext[j-7] + ssig1(ext[j-2]);
        end
        rs[0] = wk;
        for (int i = 0; i < UNROLL; i++) begin
            t1 = rs[i][7] + bsig1(rs[i][4]) + ch(rs[i][4], rs[i][5], rs[i][6])
               + k_rom[6'(cnt + 7'(i))] + ext[i];
            t2 = bsig0(rs[i][0]) + maj(rs[i][0], rs[i][1], rs[i][2]);
            rs[i+1][0] = t1 + t2;
            rs[i+1][1] = rs[i][0];
            rs[i+1][2] = rs[i][1];
            rs[i+1][3] = rs[i][2];
            rs[i+1][4] = rs[i][3] + t1;
            rs[i+1][5] = rs[i][4];
            rs[i+1][6] = rs[i][5];
            rs[i+1][7] = rs[i][6];
        end
        for (int j = 0; j < 16; j++) begin
            nwin[j] = ext[j+UNROLL];
        end
    end

    always_comb begin
        fin = '0;
        for (int j = 0; j < 8; j++) begin
            fin[255-32*j -: 32] = (FEEDFORWARD != 0) ? (ms[j] + wk[j]) : wk[j];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < 8; j++) begin
                wk[j] <= '0;
                ms[j] <= '0;
            end
            for (int j = 0; j < 16; j++) begin
                win[j] <= '0;
            end
            cnt    <= '0;
            digest <= '0;
        end else begin
            if (load) begin
                for (int j = 0; j < 8; j++) begin
                    wk[j] <= midstate[255-32*j -: 32];
                    ms[j] <= midstate[255-32*j -: 32];
                end
                for (int j = 0; j < 16; j++) begin
                    win[j] <= block[511-32*j -: 32];
                end
                cnt <= '0;
            end else if (step) begin
                wk  <= rs[UNROLL];
                win <= nwin;
                cnt <= cnt + 7'(UNROLL);
            end
            if (capture) begin
                digest <= fin;
            end
        end
    end

endmodule

// File: tb/tb_voodoo_sha_core.sv
// Bench for voodoo_sha_core: four instances (UNROLL 1/4/64 with feed-forward, UNROLL 1 without)
// share stimulus; a scoreboard holds expected digests and latencies per instance.
module tb_voodoo_sha_core;

    localparam int ND = 4;
    localparam int LAT [ND] = '{65, 17, 2, 65};
    localparam bit FFM [ND] = '{1'b1, 1'b1, 1'b1, 1'b0};

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] EMPTY_DG =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ABC_DG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         abort;
    logic         out_ready;
    logic [255:0] midstate;
    logic [511:0] block;
    logic         ir [ND];
    logic         ov [ND];
    logic         bz [ND];
    logic [255:0] dg [ND];
    logic         prev_ov [ND];

    typedef struct {
        int           dut;
        logic [255:0] dg;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    always #5 clk = ~clk;

    voodoo_sha_core #(.UNROLL(1), .FEEDFORWARD(1)) u_u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
        .midstate(midstate), .block(block), .abort(abort), .out_valid(ov[0]),
        .out_ready(out_ready), .digest(dg[0]), .busy(bz[0]));

    voodoo_sha_core #(.UNROLL(4), .FEEDFORWARD(1)) u_u4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
        .midstate(midstate), .block(block), .abort(abort), .out_valid(ov[1]),
        .out_ready(out_ready), .digest(dg[1]), .busy(bz[1]));

    voodoo_sha_core #(.UNROLL(64), .FEEDFORWARD(1)) u_u64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
        .midstate(midstate), .block(block), .abort(abort), .out_valid(ov[2]),
        .out_ready(out_ready), .digest(dg[2]), .busy(bz[2]));

    voodoo_sha_core #(.UNROLL(1), .FEEDFORWARD(0)) u_nff (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[3]),
        .midstate(midstate), .block(block), .abort(abort), .out_valid(ov[3]),
        .out_ready(out_ready), .digest(dg[3]), .busy(bz[3]));

    function automatic logic [255:0] sub_iv(input logic [255:0] x);
        logic [255:0] iv;
        logic [255:0] r;
        iv = IV;
        r  = '0;
        for (int j = 0; j < 8; j++) begin
            r[255-32*j -: 32] = x[255-32*j -: 32] - iv[255-32*j -: 32];
        end
        return r;
    endfunction

    function automatic logic [255:0] exp_for(input int d, input logic [255:0] full);
        return FFM[d] ? full : sub_iv(full);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input int d);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].dut == d) idx = i;
        end
        checks++;
        assert (idx >= 0) else begin
            errors++;
            $error("FAIL unexpected_out_u%0d observed=%h expected=no_output", d, dg[d]);
        end
        if (idx >= 0) begin
            chk($sformatf("digest_u%0d", d), dg[d], sb[idx].dg);
            chk($sformatf("latency_u%0d", d), 256'(edge_n - sb[idx].acc), 256'(LAT[d]));
            sb.delete(idx);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        for (int d = 0; d < ND; d++) begin
            if (ov[d] && !prev_ov[d]) sb_pop(d);
            prev_ov[d] = ov[d];
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic scramble();
        for (int j = 0; j < 8; j++)  midstate[32*j +: 32] = $urandom();
        for (int j = 0; j < 16; j++) block[32*j +: 32]    = $urandom();
    endtask

    task automatic send(input logic [255:0] ms, input logic [511:0] blk, output int acc);
        for (int d = 0; d < ND; d++) chk($sformatf("ready_u%0d", d), 256'(ir[d]), 256'(1));
        midstate = ms;
        block    = blk;
        in_valid = 1'b1;
        tick();
        acc      = edge_n;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic push_one(input int d, input logic [255:0] full, input int acc);
        exp_t e;
        e.dut = d;
        e.dg  = exp_for(d, full);
        e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic push_all(input logic [255:0] full, input int acc);
        for (int d = 0; d < ND; d++) push_one(d, full, acc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_in_ready_u%0d", tag, d), 256'(ir[d]), 256'(1));
            chk($sformatf("%s_busy_u%0d", tag, d), 256'(bz[d]), 256'(0));
            chk($sformatf("%s_out_valid_u%0d", tag, d), 256'(ov[d]), 256'(0));
            chk($sformatf("%s_digest_u%0d", tag, d), dg[d], 256'(0));
        end
    endtask

    initial begin
        int acc;
        int k;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        midstate  = '0;
        block     = '0;
        for (int d = 0; d < ND; d++) prev_ov[d] = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk_reset_outputs("reset");
        run(2);
        reset_n = 1'b1;
        run(2);

        // empty message and "abc" on every instance
        send(IV, EMPTY_BLK, acc);
        push_all(EMPTY_DG, acc);
        run(70);
        chk("sb_empty_msg", 256'(sb.size()), 256'(0));

        send(IV, ABC_BLK, acc);
        push_all(ABC_DG, acc);
        run(70);
        chk("sb_abc", 256'(sb.size()), 256'(0));

        // backpressure with a second job waiting
        out_ready = 1'b0;
        send(IV, ABC_BLK, acc);
        push_all(ABC_DG, acc);
        k = 0;
        while (!ov[0] && k < 80) begin
            tick();
            k++;
        end
        chk("bp_out_valid_seen", 256'(ov[0]), 256'(1));
        midstate = IV;
        block    = EMPTY_BLK;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("bp_in_ready_u%0d", d), 256'(ir[d]), 256'(0));
                chk($sformatf("bp_out_valid_u%0d", d), 256'(ov[d]), 256'(1));
                chk($sformatf("bp_digest_u%0d", d), dg[d], exp_for(d, ABC_DG));
            end
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle_in_ready", 256'(ir[0]), 256'(1));
        chk("bp_idle_out_valid", 256'(ov[0]), 256'(0));
        tick();
        chk("bp_second_accept_busy", 256'(bz[0]), 256'(1));
        acc      = edge_n;
        in_valid = 1'b0;
        scramble();
        push_all(EMPTY_DG, acc);
        run(70);
        chk("sb_backpressure", 256'(sb.size()), 256'(0));

        // abort at round 30 of the UNROLL=1 instances
        send(IV, ABC_BLK, acc);
        push_one(1, ABC_DG, acc);
        push_one(2, ABC_DG, acc);
        run(30);
        chk("abort_pre_busy", 256'(bz[0]), 256'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy_u1", 256'(bz[0]), 256'(0));
        chk("abort_in_ready_u1", 256'(ir[0]), 256'(1));
        chk("abort_out_valid_u1", 256'(ov[0]), 256'(0));
        chk("abort_busy_nff", 256'(bz[3]), 256'(0));
        chk("abort_digest_kept_u1", dg[0], EMPTY_DG);
        chk("abort_digest_kept_nff", dg[3], sub_iv(EMPTY_DG));
        run(70);
        chk("sb_abort", 256'(sb.size()), 256'(0));

        send(IV, ABC_BLK, acc);
        push_all(ABC_DG, acc);
        run(70);
        chk("sb_after_abort", 256'(sb.size()), 256'(0));

        // asynchronous reset in the middle of a job
        send(IV, ABC_BLK, acc);
        push_one(2, ABC_DG, acc);
        run(5);
        #3 reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        reset_n = 1'b1;
        run(2);
        send(IV, EMPTY_BLK, acc);
        push_all(EMPTY_DG, acc);
        run(70);
        chk("sb_after_reset", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/voodoo_sha_core.md
# voodoo_sha_core

Parametrised, iterative SHA-256 compression engine. It replaces the single combinational round fragment with a clocked core that does the following:

- runs `UNROLL` rounds per clock;
- expands the message schedule on the fly;
- applies the midstate feed-forward;
- exchanges work and digests with the job dispatcher over valid/ready handshakes.

It sits between the work-distribution logic and the nonce/target comparator. It is instantiated twice in series for double-SHA mining.

## Interface

Parameters:

- `UNROLL`, default 1: rounds evaluated per clock. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value must cause an elaboration error.
- `FEEDFORWARD`, default 1:
  - 1: digest = midstate + final state (per word, mod 2^32).
  - 0: digest = raw final state.

Ports:

- `clk`, input, 1: sole clock. Rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: job present on `midstate`/`block`.
- `in_ready`, output, 1: core can accept a job.
- `midstate`, input, 256: initial hash state. Word a is `[255:224]`, word h is `[31:0]`.
- `block`, input, 512: message block. W0 is `[511:480]`, W15 is `[31:0]`.
- `abort`, input, 1: synchronous cancel of the current job.
- `out_valid`, output, 1: digest is valid.
- `out_ready`, input, 1: downstream accepts the digest.
- `digest`, output, 256: result. H0 is `[255:224]`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation

- FSM states: IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`:
    - register `midstate` into both the working state a..h and a saved copy;
    - register `block` into a 16-word schedule window;
    - round counter ← 0;
    - go to ROUND.
- **ROUND**
  - Each clock applies `UNROLL` rounds in sequence, combinationally chained. Per round:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t];
    - T2 = Σ0(a) + Maj(a,b,c);
    - then the standard shift: e ← d+T1, a ← T1+T2.
  - Σ0 = ROTR2 ^ ROTR13 ^ ROTR22.
  - Σ1 = ROTR6 ^ ROTR11 ^ ROTR25.
  - Ch and Maj are bitwise (&, ~), never logical.
  - All additions are 32-bit, mod 2^32; carries are discarded.
  - W[t] for t ≥ 16 is W[t-16] + σ0(W[t-15]) + W[t-7] + σ1(W[t-2]).
    - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
    - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - The schedule window advances `UNROLL` words per clock.
  - K constants come from an internal 64-entry ROM indexed by counter+i.
  - Counter increments by `UNROLL`. The clock that completes round 63 moves to FINAL.
- **FINAL**
  - Compute the digest (feed-forward per `FEEDFORWARD`).
  - Register it into `digest`; go to DONE.
- **DONE**
  - `out_valid` = 1; `digest` is held stable.
  - On `out_ready` go to IDLE. `in_ready` does not rise until IDLE, so there is no same-cycle accept.
- **abort**
  - In ROUND, FINAL or DONE: next state is IDLE and `out_valid` drops at that edge.
  - No digest is emitted; `digest` keeps its last value.
  - abort in IDLE is ignored.
  - abort has priority over `out_ready` and over round completion.
- **Inputs after accept:** `midstate` and `block` are don't-care once accepted. The core never re-samples them.

## Timing

- Reset (async assert, sync release): the following take effect immediately on `reset_n` low.
  - state = IDLE;
  - `in_ready` = 1;
  - `out_valid` = 0;
  - `busy` = 0;
  - `digest` = 0;
  - counter = 0;
  - working registers = 0.
- Reset mid-job discards the job with no output.
- Latency: let N = 64/`UNROLL`, and count edges from the accept edge (edge 0).
  - Rounds occupy edges 1..N.
  - FINAL registers the result at edge N+1.
  - `out_valid` is high from edge N+1 onward.
  - UNROLL=1 gives 65 cycles; UNROLL=64 gives 2.
- Throughput: one job per N+3 clocks at best (accept, N rounds, FINAL, DONE handshake, IDLE).
- Backpressure: DONE persists indefinitely while `out_ready` = 0. `digest` and `out_valid` are stable throughout.
- `busy` = (state != IDLE), registered. It is exactly the inverse of `in_ready`.

## Test plan

- **Empty message, UNROLL=1.**
  - Stimulus: `midstate` = standard IV (6a09e667 … 5be0cd19), block = 80000000 followed by 15 zero words. Hold `out_ready` = 1.
  - Required: `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with `out_valid` first high exactly 65 edges after accept.
- **"abc", repeated for UNROLL ∈ {1, 4, 64}.**
  - Stimulus: IV, W0 = 61626380, W15 = 00000018, all other words zero.
  - Required: `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; `out_valid` at edge 65 / 17 / 2.
- **FEEDFORWARD=0, "abc".**
  - Required: `digest` equals the "abc" result minus the IV, per word mod 2^32 (H0 word = 506e3058).
- **Backpressure.**
  - Stimulus: hold `out_ready` = 0 for 20 clocks after `out_valid`, while `in_valid` = 1 with a second job.
  - Required: `in_ready` = 0 and `digest` unchanged throughout. The second job is accepted on the first IDLE cycle after `out_ready`.
- **Abort.**
  - Stimulus: assert `abort` at round 30 (UNROLL=1).
  - Required: IDLE next edge; `out_valid` never rises; the next "abc" job still produces the correct digest.
- **Async reset.**
  - Stimulus: drop `reset_n` mid-ROUND, between edges.
  - Required: `busy` = 0 and `in_ready` = 1 immediately; `out_valid` = 0; a fresh job after release is correct.
